// File: rtl/pg_pkg.sv
// pg_pkg: shared definitions for the streaming test-pattern generator.
// Holds pattern mode encodings, FSM state encodings and a small helper
// used when sampling the seed at the start of a run.
package pg_pkg;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pg_state_e;

  // LFSR and walking-ones lock up on an all-zero word, so those modes
  // replace a zero seed with 1.
  function automatic logic mode_needs_nonzero(input logic [1:0] m);
    return (m == MODE_LFSR) || (m == MODE_WALK);
  endfunction

endpackage

// File: rtl/pg_next_word.sv
// pg_next_word: purely combinational successor function for the pattern
// generator. Given the current word and mode it returns the next word of
// the sequence. TAPS is the Galois feedback mask already cut to DATA_W.
module pg_next_word
  import pg_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] TAPS   = '0
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] next_data
);

  // Select the successor word for the active pattern.
  always_comb begin
    next_data = data;
    case (mode)
      MODE_COUNT: next_data = data + DATA_W'(1);
      MODE_LFSR:  next_data = data[0] ? ((data >> 1) ^ TAPS) : (data >> 1);
      MODE_WALK:  next_data = {data[DATA_W-2:0], data[DATA_W-1]};
      default:    next_data = data;
    endcase
  end

endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: streaming test-pattern source (counter, LFSR,
// walking-ones, constant) with fixed-length or continuous runs.
// Optional build macro PG_ERR_INJECT_EN adds the err_inj input, which
// corrupts bit 0 of exactly one beat without disturbing the sequence.
//
// Stream handshake: a beat transfers on a rising clk edge where
// ge_valid && ge_ready. Once ge_valid is high it stays high, with ge_data
// and ge_last stable, until that transfer happens; ge_ready may change
// freely and has no combinational path to any output.
module pattern_generator
  import pg_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BURST_W   = 16,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  seed,
  input  logic [BURST_W-1:0] burst_len,
  output logic [DATA_W-1:0]  ge_data,
  output logic               ge_valid,
  input  logic               ge_ready,
  output logic               ge_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
`ifdef PG_ERR_INJECT_EN
  ,
  input  logic               err_inj
`endif
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

  pg_state_e          state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               done_q, done_d;
  logic               load_new;
  logic               accept;
  logic [DATA_W-1:0]  next_data;
  logic [DATA_W-1:0]  seed_adj;

  assign accept = valid_q & ge_ready;

  pg_next_word #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_next (
    .mode      (mode_q),
    .data      (data_q),
    .next_data (next_data)
  );

  // Seed as it will be loaded: zero replaced by 1 for LFSR/WALK.
  always_comb begin
    seed_adj = seed;
    if (mode_needs_nonzero(mode) && (seed == '0)) seed_adj = DATA_W'(1);
  end

  // Next-state, next-beat and burst-counter logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    load_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_RUN;
          mode_d   = mode;
          data_d   = seed_adj;
          cnt_d    = burst_len;
          valid_d  = 1'b1;
          last_d   = (burst_len == BURST_W'(1));
          load_new = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (last_q || stop) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d   = next_data;
            // A zero counter means continuous mode: never count down.
            if (cnt_q != '0) cnt_d = cnt_q - BURST_W'(1);
            last_d   = (cnt_q == BURST_W'(2));
            load_new = 1'b1;
          end
        end else if (stop) begin
          if (valid_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and stream registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_COUNT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef PG_ERR_INJECT_EN
  // err_pend remembers a request; err_cur marks the beat on the wire as
  // corrupted. The mark is only attached when a fresh beat is loaded so a
  // stalled beat never changes under the consumer.
  logic err_pend, err_cur;

  // Single-shot error flag tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend <= 1'b0;
      err_cur  <= 1'b0;
    end else if (load_new) begin
      err_cur  <= err_pend | err_inj;
      err_pend <= 1'b0;
    end else begin
      if (accept)  err_cur  <= 1'b0;
      if (err_inj) err_pend <= 1'b1;
    end
  end

  assign ge_data = data_q ^ {{(DATA_W-1){1'b0}}, err_cur};
`else
  assign ge_data = data_q;
`endif

  assign ge_valid  = valid_q;
  assign ge_last   = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
